// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Purpose:
//   Several requesters share one OPERAND_WIDTH-bit adder. Each cycle a
//   round-robin arbiter picks one valid requester, adds its operands and
//   captures the sum in a single output register. The register has
//   valid/ready backpressure, so a drain and a new accept can happen in the
//   same cycle. Latency is one cycle and throughput is one add per cycle.
//
// Ports:
//   clk        - sole clock; all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   req_valid  - per-requester valid (NUM_REQ bits)
//   req_a      - packed operand A, requester i at [i*W +: W]
//   req_b      - packed operand B, same packing as req_a
//   req_ready  - one-hot or zero; the requester accepted this cycle
//   out_valid  - the result register holds a valid result
//   out_ready  - the consumer takes the result this cycle
//   out_res    - (a + b) mod 2^W
//   out_carry  - carry out of bit W-1
//   out_id     - index of the requester that produced the result
//   acc_count  - number of accepted operations, wraps at 2^32
// -----------------------------------------------------------------------------
module adder_arbiter #(
    parameter int OPERAND_WIDTH = 32,
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OPERAND_WIDTH-1:0]         out_res,
    output logic                             out_carry,
    output logic [ID_W-1:0]                  out_id,
    output logic [31:0]                      acc_count
);

    // Priority pointer and result register.
    logic [ID_W-1:0]          r_last_grant;
    logic                     r_out_valid;
    logic [OPERAND_WIDTH-1:0] r_out_res;
    logic                     r_out_carry;
    logic [ID_W-1:0]          r_out_id;
    logic [31:0]              r_acc_count;

    // Arbitration and datapath.
    logic                     w_hi_found;
    logic                     w_lo_found;
    logic [ID_W-1:0]          w_hi_idx;
    logic [ID_W-1:0]          w_lo_idx;
    logic                     w_found;
    logic [ID_W-1:0]          w_winner;
    logic                     w_can_accept;
    logic                     w_accept;
    logic [OPERAND_WIDTH-1:0] w_op_a;
    logic [OPERAND_WIDTH-1:0] w_op_b;
    logic [OPERAND_WIDTH:0]   w_sum;

    // Round-robin search split into two ranges: indices above the pointer
    // come first in the search order, then indices at or below it. Scanning
    // downwards leaves the lowest valid index of each range, so the winner
    // is the lowest above the pointer, else the lowest at or below it.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment so that no path leaves it unassigned and
        // no latch is inferred.
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[ID_W'(i)]) begin
                if (ID_W'(i) > r_last_grant) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = ID_W'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = ID_W'(i);
                end
            end
        end
    end

    assign w_found      = w_hi_found || w_lo_found;
    assign w_winner     = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_accept     = w_found && w_can_accept;
    assign req_ready    = w_accept ? (NUM_REQ'(1) << w_winner) : '0;

    // Operand mux for the winning requester.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_winner) begin
                w_op_a = req_a[i*OPERAND_WIDTH +: OPERAND_WIDTH];
                w_op_b = req_b[i*OPERAND_WIDTH +: OPERAND_WIDTH];
            end
        end
    end

    // Zero-extend both operands so the top bit of the sum is the carry.
    assign w_sum = {1'b0, w_op_a} + {1'b0, w_op_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_out_valid  <= 1'b0;
            r_out_res    <= '0;
            r_out_carry  <= 1'b0;
            r_out_id     <= '0;
            r_acc_count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement
            // order or of other always_ff blocks.
            if (w_accept) begin
                r_out_res    <= w_sum[OPERAND_WIDTH-1:0];
                r_out_carry  <= w_sum[OPERAND_WIDTH];
                r_out_id     <= w_winner;
                r_out_valid  <= 1'b1;
                r_last_grant <= w_winner;
                r_acc_count  <= r_acc_count + 32'd1;
            end else if (out_ready) begin
                // Drain without refill; the data fields keep their values.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_carry = r_out_carry;
    assign out_id    = r_out_id;
    assign acc_count = r_acc_count;

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Purpose:
//   Self-checking bench for adder_arbiter (default parameters). Directed
//   sequences with constant expectations, a table of arithmetic vectors and
//   a randomized run compared against a behavioural model of the
//   round-robin adder.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_res;
    logic             out_carry;
    logic [IW-1:0]    out_id;
    logic [31:0]      acc_count;

    adder_arbiter #(
        .OPERAND_WIDTH(W),
        .NUM_REQ      (N),
        .ID_W         (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .out_carry(out_carry),
        .out_id   (out_id),
        .acc_count(acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    logic          m_valid;
    logic [W:0]    m_sum;
    int            m_id;
    logic [31:0]   m_count;
    int            m_last;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        carry;
    } arith_vec_t;

    arith_vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = 0;
        m_count = '0;
        m_last  = N - 1;
    endtask

    // First requester with valid set, searching last+1, last+2, ... mod N.
    function automatic int m_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (v[idx[IW-1:0]]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: check req_ready before the edge, advance the model
    // at the edge, then check the registered outputs just after it.
    task automatic tick(output logic [N-1:0] rdy);
        int           w;
        logic         can;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] a;
        logic [W-1:0] b;
        #1;
        w       = m_pick(req_valid, m_last);
        can     = !m_valid || out_ready;
        exp_rdy = (w >= 0 && can) ? (4'b0001 << w) : 4'b0000;
        check("req_ready", req_ready, exp_rdy);
        rdy = req_ready;
        if (w >= 0) begin
            a = req_a[w*W +: W];
            b = req_b[w*W +: W];
        end else begin
            a = '0;
            b = '0;
        end
        @(posedge clk);
        if (w >= 0 && can) begin
            m_sum   = {1'b0, a} + {1'b0, b};
            m_id    = w;
            m_valid = 1'b1;
            m_last  = w;
            m_count = m_count + 32'd1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_res",   out_res,   m_sum[W-1:0]);
        check("out_carry", out_carry, m_sum[W]);
        check("out_id",    out_id,    m_id[IW-1:0]);
        check("acc_count", acc_count, m_count);
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    logic [N-1:0] rdy;
    logic [N-1:0] seq_rdy[5];
    logic [IW-1:0] seq_id[5];
    logic [N-1:0] fair_rdy[4];
    logic [N-1:0] pend;

    initial begin
        vecs[0] = '{id: 2, a: 32'hFFFF_FFFF, b: 32'h0000_0001, res: 32'h0000_0000, carry: 1'b1};
        vecs[1] = '{id: 2, a: 32'h1234_0000, b: 32'h0000_5678, res: 32'h1234_5678, carry: 1'b0};
        vecs[2] = '{id: 0, a: 32'h0000_0000, b: 32'h0000_0000, res: 32'h0000_0000, carry: 1'b0};
        vecs[3] = '{id: 3, a: 32'h8000_0000, b: 32'h8000_0000, res: 32'h0000_0000, carry: 1'b1};
        vecs[4] = '{id: 1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'hFFFF_FFFE, carry: 1'b1};
        vecs[5] = '{id: 0, a: 32'h7FFF_FFFF, b: 32'h0000_0001, res: 32'h8000_0000, carry: 1'b0};

        seq_rdy[0] = 4'b0001; seq_rdy[1] = 4'b0010; seq_rdy[2] = 4'b0100;
        seq_rdy[3] = 4'b1000; seq_rdy[4] = 4'b0001;
        seq_id[0] = 2'd0; seq_id[1] = 2'd1; seq_id[2] = 2'd2; seq_id[3] = 2'd3; seq_id[4] = 2'd0;
        fair_rdy[0] = 4'b1000; fair_rdy[1] = 4'b0001;
        fair_rdy[2] = 4'b1000; fair_rdy[3] = 4'b0001;

        // ---- Reset state ----
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_res",   out_res,   32'd0);
        check("rst_out_id",    out_id,    2'd0);
        check("rst_acc_count", acc_count, 32'd0);
        req_valid = 4'b1111;
        #1;
        check("rst_req_ready", req_ready, 4'b0001);
        @(negedge clk);
        rst = 1'b0;

        // ---- First grants: 0,1,2,3,0 with out_id one cycle behind ----
        for (int i = 0; i < N; i++) set_ops(i, 32'h100 * (i + 1), 32'h1 + i);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(rdy);
            check("rr_grant", rdy, seq_rdy[i]);
            check("rr_out_id", out_id, seq_id[i]);
        end
        check("rr_acc_count5", acc_count, 32'd5);

        // ---- Arithmetic vectors ----
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b0001 << vecs[i].id;
            set_ops(vecs[i].id, vecs[i].a, vecs[i].b);
            tick(rdy);
            check("arith_res",   out_res,   vecs[i].res);
            check("arith_carry", out_carry, vecs[i].carry);
            check("arith_id",    out_id,    vecs[i].id[IW-1:0]);
        end

        // ---- Backpressure: stall 3 cycles, then drain + accept together ----
        req_valid = 4'b0010;
        set_ops(1, 32'h0000_00AA, 32'h0000_0055);
        tick(rdy);
        req_valid = 4'b1000;
        set_ops(3, 32'h0000_0007, 32'h0000_0008);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(rdy);
            check("stall_ready", rdy, 4'b0000);
            check("stall_res",   out_res, 32'h0000_00FF);
            check("stall_id",    out_id, 2'd1);
            check("stall_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        tick(rdy);
        check("refill_ready", rdy, 4'b1000);
        check("refill_valid", out_valid, 1'b1);
        check("refill_id",    out_id, 2'd3);
        check("refill_res",   out_res, 32'h0000_000F);

        // ---- Fairness: requester 0 continuous, requester 3 joins ----
        req_valid = 4'b0001;
        for (int i = 0; i < 10; i++) tick(rdy);
        req_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick(rdy);
            check("fair_grant", rdy, fair_rdy[i]);
        end

        // ---- Reset mid-operation while stalled ----
        req_valid = '0;
        tick(rdy);
        req_valid = 4'b0100;
        out_ready = 1'b0;
        tick(rdy);
        check("pre_rst_valid", out_valid, 1'b1);
        req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_res",   out_res, 32'd0);
        check("async_rst_count", acc_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0101;
        out_ready = 1'b1;
        tick(rdy);
        check("post_rst_grant", rdy, 4'b0001);

        // ---- Counter wrap ----
        force dut.r_acc_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_acc_count;
        #1;
        check("wrap_preload", acc_count, 32'hFFFF_FFFF);
        m_count = 32'hFFFF_FFFF;
        req_valid = 4'b0100;
        tick(rdy);
        check("wrap_count", acc_count, 32'd0);

        // ---- Randomized run against the model ----
        pend      = '0;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    set_ops(i,
                            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom);
                end
            end
            req_valid = pend;
            out_ready = ($urandom_range(0, 9) < 7);
            tick(rdy);
            pend = pend & ~rdy;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
